// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles UART bytes into a terminated line and
// hands the held line out one byte per rd_en request.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   received        one-cycle strobe, rx_byte valid
//   rx_byte         received byte
//   recv_error      one-cycle framing-error strobe
//   rd_en           request next byte of the held line
//   line_ready      a completed line is held and readable
//   line_len        bytes stored in the current line
//   truncated       held line was ended by a full buffer
//   rd_data         byte returned for the previous rd_en
//   rd_valid        one-cycle strobe, rd_data valid
//   err_count       saturating count of recv_error strobes
//   drop_count      saturating count of bytes dropped in HOLD
module uart_line_rx #(
    parameter int unsigned DEPTH = 32,
    parameter logic [7:0]  TERM  = 8'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    input  logic       rd_en,
    output logic       line_ready,
    output logic [5:0] line_len,
    output logic       truncated,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] err_count,
    output logic [7:0] drop_count
);

    // Buffer is rounded up to a power of two so the address slices
    // of line_len/ptr index it exactly.
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << AW;
    localparam logic [5:0]  FULL  = 6'(DEPTH);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mem [SLOTS];
    logic [5:0] len_q, len_d;
    logic [5:0] ptr_q, ptr_d;
    logic       trunc_q, trunc_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] err_q, err_d;
    logic [7:0] drop_q, drop_d;
    logic       wr_en;
    logic [5:0] len_inc;
    logic       last_rd;

    assign len_inc = len_q + 6'd1;
    // ptr reaching the final stored byte ends the readout.
    assign last_rd = (ptr_q == (len_q - 6'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            len_q      <= '0;
            ptr_q      <= '0;
            trunc_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            trunc_q    <= trunc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    // Line storage needs no reset: line_len gates what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_q[AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        trunc_d    = trunc_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;

        if (recv_error && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        unique case (state_q)
            COLLECT: begin
                // An error in the same cycle as a byte discards both
                // the byte and the partial line.
                if (recv_error) begin
                    len_d = '0;
                end else if (received) begin
                    if (rx_byte != TERM) begin
                        wr_en = 1'b1;
                        len_d = len_inc;
                        if (len_inc == FULL) begin
                            state_d = HOLD;
                            trunc_d = 1'b1;
                        end
                    end else if (len_q != 6'd0) begin
                        state_d = HOLD;
                        trunc_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (received && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem[ptr_q[AW-1:0]];
                    ptr_d      = ptr_q + 6'd1;
                    if (last_rd) begin
                        state_d = COLLECT;
                        ptr_d   = '0;
                        len_d   = '0;
                        trunc_d = 1'b0;
                    end
                end
            end
        endcase
    end

    assign line_ready = (state_q == HOLD);
    assign line_len   = len_q;
    assign truncated  = trunc_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign err_count  = err_q;
    assign drop_count = drop_q;

endmodule
